// File: rtl/ecat_pkg.sv
// Shared definitions for the EtherCAT datagram parser: command codes, FSM states,
// header byte offsets and the default maximum datagram length.
package ecat_pkg;

    localparam logic [10:0] MAX_LEN_DEF = 11'd1486;

    localparam logic [3:0] ADDR_OFS = 4'd2;
    localparam logic [3:0] LEN_OFS  = 4'd6;
    localparam logic [3:0] IRQ_OFS  = 4'd8;
    localparam logic [3:0] HDR_LEN  = 4'd10;

    typedef enum logic [7:0] {
        CMD_NOP  = 8'h00,
        CMD_APRD = 8'h01,
        CMD_APWR = 8'h02,
        CMD_APRW = 8'h03,
        CMD_FPRD = 8'h04,
        CMD_FPWR = 8'h05,
        CMD_FPRW = 8'h06,
        CMD_BRD  = 8'h07,
        CMD_BWR  = 8'h08,
        CMD_BRW  = 8'h09,
        CMD_LRD  = 8'h0A,
        CMD_LWR  = 8'h0B,
        CMD_LRW  = 8'h0C
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_WKC0,
        ST_WKC1,
        ST_SKIP
    } state_e;

    function automatic logic cmd_reads(input logic [7:0] cmd);
        return (cmd == CMD_LRD) || (cmd == CMD_LRW);
    endfunction

    function automatic logic cmd_writes(input logic [7:0] cmd);
        return (cmd == CMD_LWR) || (cmd == CMD_LRW);
    endfunction

endpackage

// File: rtl/ecat_wkc_upd.sv
// Working-counter update: adds the hit increment to the WKC low byte and
// ripples the registered carry into the high byte one byte later.
module ecat_wkc_upd #(
    parameter logic [1:0] WKC_RD_INC = 2'd1,
    parameter logic [1:0] WKC_WR_INC = 2'd1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lo_en,
    input  logic [7:0] data,
    input  logic       rd,
    input  logic       wr,
    input  logic       is_lrw,
    output logic [7:0] lo,
    output logic [7:0] hi
);

    logic [2:0] inc;
    logic [8:0] sum;
    logic       carry_q;

    // NOTE: every variable gets a default first so no path can infer a latch.
    always_comb begin
        inc = 3'd0;
        if (rd) inc = inc + {1'b0, WKC_RD_INC};
        if (wr) inc = inc + (is_lrw ? 3'd2 : {1'b0, WKC_WR_INC});
    end

    assign sum = {1'b0, data} + {6'd0, inc};
    assign lo  = sum[7:0];
    assign hi  = data + {7'd0, carry_q};

    // NOTE: sequential state uses non-blocking assignment so all registers sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     carry_q <= 1'b0;
        else if (lo_en) carry_q <= sum[8];
    end

endmodule

// File: rtl/ecat_dgram_parser.sv
// EtherCAT datagram parser: walks the datagram headers, drives FMMU logical
// strobes per data byte, and forwards the stream with the WKC bytes updated.
module ecat_dgram_parser
    import ecat_pkg::*;
#(
    parameter logic [10:0] MAX_LEN    = MAX_LEN_DEF,
    parameter logic [1:0]  WKC_RD_INC = 2'd1,
    parameter logic [1:0]  WKC_WR_INC = 2'd1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic        rx_sof,
    input  logic        rx_eof,
    input  logic [7:0]  rx_data,
    output logic [31:0] laddr,
    output logic        lrd,
    output logic        lwr,
    input  logic        rdaddr_hit,
    input  logic        wraddr_hit,
    output logic        tx_valid,
    output logic        tx_sof,
    output logic        tx_eof,
    output logic [7:0]  tx_data,
    output logic        tx_is_data,
    output logic        dgram_done,
    output logic        err
);

    state_e      state_q, state_d;
    logic [3:0]  hdr_cnt_q, hdr_cnt_d;
    logic [10:0] data_cnt_q, data_cnt_d;

    logic [7:0]  cmd_q;
    logic [31:0] start_addr_q;
    logic [10:0] len_q;
    logic        more_q;
    logic        rd_seen_q, wr_seen_q;

    logic        hdr_en;
    logic [3:0]  hdr_idx;
    logic        data_byte, wkc_lo_byte, wkc_hi_byte;
    logic        err_d, done_d;
    logic        rd_hit_now, wr_hit_now;
    logic [7:0]  wkc_lo, wkc_hi, tx_data_d;

    assign rd_hit_now = lrd & rdaddr_hit;
    assign wr_hit_now = lwr & wraddr_hit;

    always_comb begin
        state_d     = state_q;
        hdr_cnt_d   = hdr_cnt_q;
        data_cnt_d  = data_cnt_q;
        hdr_en      = 1'b0;
        hdr_idx     = hdr_cnt_q;
        data_byte   = 1'b0;
        wkc_lo_byte = 1'b0;
        wkc_hi_byte = 1'b0;
        err_d       = 1'b0;
        done_d      = 1'b0;

        if (rx_valid) begin
            // A start-of-frame byte is always header byte0, wherever the FSM was.
            if (rx_sof) begin
                hdr_en     = 1'b1;
                hdr_idx    = 4'd0;
                err_d      = (state_q != ST_IDLE);
                data_cnt_d = '0;
                if (rx_eof) begin
                    state_d   = ST_IDLE;
                    hdr_cnt_d = '0;
                    err_d     = 1'b1;
                end else begin
                    state_d   = ST_HDR;
                    hdr_cnt_d = 4'd1;
                end
            end else begin
                unique case (state_q)
                    ST_IDLE: ;
                    ST_HDR: begin
                        hdr_en = 1'b1;
                        if (rx_eof) begin
                            state_d   = ST_IDLE;
                            hdr_cnt_d = '0;
                            err_d     = 1'b1;
                        end else if (hdr_cnt_q == HDR_LEN - 4'd1) begin
                            hdr_cnt_d  = '0;
                            data_cnt_d = '0;
                            if (len_q > MAX_LEN) begin
                                state_d = ST_SKIP;
                                err_d   = 1'b1;
                            end else if (len_q == 11'd0) begin
                                state_d = ST_WKC0;
                            end else begin
                                state_d = ST_DATA;
                            end
                        end else begin
                            hdr_cnt_d = hdr_cnt_q + 4'd1;
                        end
                    end
                    ST_DATA: begin
                        data_byte = 1'b1;
                        if (rx_eof) begin
                            state_d    = ST_IDLE;
                            data_cnt_d = '0;
                            err_d      = 1'b1;
                        end else if (data_cnt_q == len_q - 11'd1) begin
                            state_d    = ST_WKC0;
                            data_cnt_d = '0;
                        end else begin
                            data_cnt_d = data_cnt_q + 11'd1;
                        end
                    end
                    ST_WKC0: begin
                        wkc_lo_byte = 1'b1;
                        if (rx_eof) begin
                            state_d = ST_IDLE;
                            err_d   = 1'b1;
                        end else begin
                            state_d = ST_WKC1;
                        end
                    end
                    ST_WKC1: begin
                        wkc_hi_byte = 1'b1;
                        done_d      = 1'b1;
                        hdr_cnt_d   = '0;
                        unique case ({more_q, rx_eof})
                            2'b10: state_d = ST_HDR;
                            2'b01: state_d = ST_IDLE;
                            2'b00: state_d = ST_SKIP;
                            2'b11: begin
                                state_d = ST_IDLE;
                                err_d   = 1'b1;
                            end
                        endcase
                    end
                    ST_SKIP: if (rx_eof) state_d = ST_IDLE;
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            hdr_cnt_q  <= '0;
            data_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hdr_cnt_q  <= hdr_cnt_d;
            data_cnt_q <= data_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q        <= '0;
            start_addr_q <= '0;
            len_q        <= '0;
            more_q       <= 1'b0;
        end else if (hdr_en) begin
            case (hdr_idx)
                4'd0:            cmd_q               <= rx_data;
                ADDR_OFS:        start_addr_q[7:0]   <= rx_data;
                ADDR_OFS + 4'd1: start_addr_q[15:8]  <= rx_data;
                ADDR_OFS + 4'd2: start_addr_q[23:16] <= rx_data;
                ADDR_OFS + 4'd3: start_addr_q[31:24] <= rx_data;
                LEN_OFS:         len_q[7:0]          <= rx_data;
                LEN_OFS + 4'd1: begin
                    len_q[10:8] <= rx_data[2:0];
                    more_q      <= rx_data[7];
                end
                default: ;
            endcase
        end
    end

    // Hits may land in idle cycles after the last strobe, so the flags sample every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_seen_q <= 1'b0;
            wr_seen_q <= 1'b0;
        end else if (hdr_en && hdr_idx == 4'd0) begin
            rd_seen_q <= 1'b0;
            wr_seen_q <= 1'b0;
        end else begin
            if (rd_hit_now) rd_seen_q <= 1'b1;
            if (wr_hit_now) wr_seen_q <= 1'b1;
        end
    end

    ecat_wkc_upd #(
        .WKC_RD_INC (WKC_RD_INC),
        .WKC_WR_INC (WKC_WR_INC)
    ) u_wkc_upd (
        .clk    (clk),
        .rst_n  (rst_n),
        .lo_en  (wkc_lo_byte),
        .data   (rx_data),
        .rd     (rd_seen_q | rd_hit_now),
        .wr     (wr_seen_q | wr_hit_now),
        .is_lrw (cmd_q == CMD_LRW),
        .lo     (wkc_lo),
        .hi     (wkc_hi)
    );

    assign tx_data_d = wkc_lo_byte ? wkc_lo :
                       wkc_hi_byte ? wkc_hi : rx_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_valid   <= 1'b0;
            tx_sof     <= 1'b0;
            tx_eof     <= 1'b0;
            tx_data    <= '0;
            tx_is_data <= 1'b0;
            lrd        <= 1'b0;
            lwr        <= 1'b0;
            laddr      <= '0;
            err        <= 1'b0;
            dgram_done <= 1'b0;
        end else begin
            tx_valid   <= rx_valid;
            tx_sof     <= rx_sof;
            tx_eof     <= rx_eof;
            tx_data    <= tx_data_d;
            tx_is_data <= data_byte;
            lrd        <= data_byte & cmd_reads(cmd_q);
            lwr        <= data_byte & cmd_writes(cmd_q);
            if (data_byte && (cmd_reads(cmd_q) || cmd_writes(cmd_q)))
                laddr <= start_addr_q + {21'd0, data_cnt_q};
            err        <= err_d;
            dgram_done <= done_d;
        end
    end

endmodule

// File: doc/ecat_dgram_parser.md
Name: ecat_dgram_parser

Overview:
- Parses the EtherCAT datagram byte stream arriving from the frame receiver, upstream of the FMMU block.
- For logical commands (LRD/LWR/LRW) it drives the FMMU's laddr/lrd/lwr inputs, one strobe per data byte.
- It samples the FMMU's rdaddr_hit/wraddr_hit responses and updates the datagram working counter (WKC).
- It forwards the stream with one cycle of latency to the downstream memory-access/transmit stage.

Parameters:
- MAX_LEN, 11'd1486: largest legal datagram data length; a larger length flags an error.
- WKC_RD_INC, 2'd1: WKC increment for a read hit.
- WKC_WR_INC, 2'd1: WKC increment for a write hit on LWR. A write hit on LRW always adds 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous assert, active-low
- rx_valid  in  1  input byte valid; no backpressure, every valid byte is consumed
- rx_sof  in  1  first byte of frame's first datagram (Ethernet/EtherCAT header already stripped)
- rx_eof  in  1  last byte of frame
- rx_data  in  8  input byte
- laddr  out  32  logical address of current data byte
- lrd  out  1  logical read strobe
- lwr  out  1  logical write strobe
- rdaddr_hit  in  1  FMMU read hit, combinational response to laddr/lrd
- wraddr_hit  in  1  FMMU write hit, combinational response to laddr/lwr
- tx_valid  out  1  output byte valid
- tx_sof  out  1  delayed rx_sof
- tx_eof  out  1  delayed rx_eof
- tx_data  out  8  output byte; WKC bytes substituted
- tx_is_data  out  1  tx byte is a datagram data byte
- dgram_done  out  1  one-cycle pulse with the WKC high byte
- err  out  1  one-cycle pulse on a protocol error

Behaviour:
- Reset values: all outputs 0, state IDLE, all counters, flags and header registers 0.
- Datagram layout, little-endian:
  - byte0 cmd, byte1 idx, bytes2-5 address.
  - bytes6-7 {M[15], C[14], rsvd[13:11], len[10:0]}.
  - bytes8-9 irq, then len data bytes, then WKC lo and WKC hi.
- States: IDLE, HDR (hdr_cnt 0..9), DATA (data_cnt 0..len-1), WKC0, WKC1, SKIP.
- IDLE -> HDR on rx_valid & rx_sof. That byte is hdr byte0.
- HDR -> DATA after byte9 if len != 0; HDR -> WKC0 if len == 0.
- DATA -> WKC0 after data byte len-1.
- WKC0 -> WKC1 on the next valid byte.
- WKC1 exit:
  - M=1 and no rx_eof -> HDR, hdr_cnt 0, next datagram.
  - M=0 and rx_eof -> IDLE.
  - M=0 and no rx_eof -> SKIP; trailing bytes pass through untouched.
  - M=1 and rx_eof -> err, then IDLE.
- SKIP -> IDLE on rx_eof.
- Idle cycles (rx_valid=0) hold state and counters in any state.
- Pass-through path: tx_* = rx_* registered, one-cycle latency. tx_valid follows rx_valid exactly.
- Logical strobes:
  - A command is logical if cmd is LRD 0x0A, LWR 0x0B or LRW 0x0C.
  - For each DATA byte of a logical command, in the cycle the byte is on tx:
    - laddr = start_addr + data_cnt, 32-bit, wraps modulo 2^32.
    - lrd asserted for LRD/LRW; lwr asserted for LWR/LRW.
  - Non-logical commands: lrd=lwr=0 and WKC is passed through unchanged.
- Hit accumulation:
  - rd_seen and wr_seen are sticky flags, cleared at hdr byte0.
  - Set when lrd&rdaddr_hit or lwr&wraddr_hit in any cycle.
  - The hit for the final data byte coincides with WKC lo on rx, so the increment uses rd_seen|(lrd&rdaddr_hit), and likewise for writes.
- WKC arithmetic:
  - inc = (rd ? WKC_RD_INC : 0) + (wr ? (cmd==LRW ? 2 : WKC_WR_INC) : 0).
  - tx WKC lo = rx lo + inc, 8-bit; the carry is registered.
  - tx WKC hi = rx hi + carry, wrapping 0xFFFF -> 0x0000.
- Errors, each giving an err pulse:
  - len > MAX_LEN: state -> SKIP, no strobes.
  - rx_eof before WKC1: abort, -> IDLE.
  - rx_sof in any state other than IDLE: that byte restarts HDR byte0.
- Reset mid-frame: immediate return to IDLE. Downstream discards the partial frame because tx_eof is never seen.

Decomposition:
- Shared package ecat_pkg holds:
  - command codes NOP..LRW (LRD 0x0A, LWR 0x0B, LRW 0x0C);
  - state encodings;
  - header offsets (ADDR_OFS 2, LEN_OFS 6, IRQ_OFS 8, HDR_LEN 10);
  - the MAX_LEN default.
- One sub-module, ecat_wkc_upd: combinational increment plus registered carry for the two WKC bytes.

Test Plan:
- LRD, addr 0x00010000, len 4, wkc 0x0000, FMMU hits on 0x10002 only:
  - lrd high for 4 cycles, laddr 0x10000..0x10003, lwr=0.
  - tx WKC = 0x0001, dgram_done pulses once.
- LRW, len 2, read and write hit, wkc 0x00FF -> tx WKC 0x0102 (inc 3, carry into hi byte).
- Two chained datagrams (APRD M=1, then LWR len 1 with a miss):
  - APRD bytes pass through unchanged, no strobes.
  - LWR WKC unchanged; state IDLE after eof.
- LWR, addr 0xFFFFFFFE, len 3 -> laddr 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
- len 0 LRD -> WKC follows the irq bytes directly, no strobes, WKC unchanged.
- Error cases:
  - rx_eof at data byte 1 of a len-4 datagram -> err pulse, IDLE.
  - len 1500 -> err, SKIP, no strobes.
  - rx_sof mid-DATA -> err, header restarts.
